seg_display_mux: RTL
====================

Name: seg_display_mux

Overview:
- Parametrised multi-digit 7-segment driver: time-multiplexed anodes with a programmable refresh prescaler.
- Sequential (iterative double-dabble) binary-to-BCD conversion; hex mode bypasses it.
- Options: leading-zero blanking, per-digit decimal points, overflow indication.
- Sits between the mouse/cursor/status datapath and the board's AN/SEG/DP pins; replaces the fixed 3-digit, 10-bit, scan-every-clock driver.

Parameters:
- NUM_DIGITS, 4, number of digits/anodes driven (1..8).
- VALUE_W, 14, width of the binary input value (1..27).
- REFRESH_DIV, 100000, clk cycles each digit stays lit (>=2).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- value  in  VALUE_W  binary value to display; sampled only on load.
- load  in  1  single-cycle request to capture value, hex_mode and blank_lz.
- hex_mode  in  1  1: show value as hex nibbles; 0: decimal.
- blank_lz  in  1  1: blank leading zeros.
- dp_mask  in  NUM_DIGITS  bit i=1 lights the DP of digit i; used live, not captured.
- busy  out  1  conversion in progress.
- AN  out  NUM_DIGITS  anode enables, active-low, one-hot-low.
- SEG  out  7  segments a..g on SEG[6]..SEG[0], active-low.
- DP  out  1  decimal point, active-low.

Behaviour:
- Reset (async assert, sync release):
  - AN=all 1s, SEG=7'b1111111, DP=1, busy=0.
  - Prescaler=0, scan index=0.
  - Display digit register = all zero, overflow=0, mode=decimal, blank_lz=0.
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the scan index advances 0,1,..,NUM_DIGITS-1,0.
- Outputs are registered from the current index. AN[idx]=0 at all times after the first clk edge following reset.
  - AN, SEG and DP change together, exactly 1 cycle after an index or digit-register change. No glitch cycle with two anodes low.
- Capture (load=1 while busy=0):
  - Latch value, hex_mode, blank_lz.
  - overflow := !hex_mode && value >= 10**NUM_DIGITS.
  - Hex overflow := value >> (4*NUM_DIGITS) != 0.
- Hex mode: no conversion. Digit register updates on the cycle after load. busy stays 0.
- Decimal mode: busy=1 on the cycle after load.
  - Each cycle: add-3 to every BCD nibble >=5, then shift one value bit in, MSB first.
  - VALUE_W iterations. On the final iteration the digit register is written atomically and busy falls. busy is high for exactly VALUE_W cycles.
  - Until completion the display keeps showing the previous result; no partial digits are ever visible.
  - BCD accumulator is NUM_DIGITS nibbles; higher digits are discarded (covered by overflow).
- load while busy=1 is ignored. No queueing.
- Overflow=1: every digit shows dash (SEG=7'b1111110). DP still follows dp_mask.
- Leading-zero blanking (blank_lz=1, both modes):
  - Digit i is blank (7'b1111111) if it and all digits above it are zero.
  - Digit 0 is never blanked, so value 0 shows "0".
- Encoding:
  - 0..9 use the standard active-low patterns (0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100).
  - A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- DP = ~dp_mask[idx], sampled live and registered with SEG.
- Reset mid-conversion: aborts, busy=0, digits cleared. A later load behaves normally.
- REFRESH_DIV=2 and NUM_DIGITS=1 must work. With NUM_DIGITS=1, AN is a constant 0 after reset.

Decomposition:
- Shared package seg_pkg:
  - Active-low segment constants SEG_0..SEG_F, SEG_BLANK, SEG_DASH.
  - Function nibble_to_seg(nibble).
  - Localparam helper for 10**N.
- Sub-module bin2bcd_seq (params VALUE_W, NUM_DIGITS; ports start, bin, busy, done, bcd) holds the iterative converter.
- Top module holds prescaler, scan index, capture/overflow, blanking and output registers.

Test Plan:
- Reset check: with rst held then released (NUM_DIGITS=4, REFRESH_DIV=4), outputs are AN=1111, SEG=1111111, DP=1 during reset. One cycle after release, AN=1110. AN rotates 1110->1101->1011->0111->1110, each held exactly 4 cycles.
- Decimal conversion: load value=1234, hex_mode=0, blank_lz=0 -> busy high exactly 14 cycles. Old digits shown throughout. Then digits 3..0 = 1,2,3,4; digit 0 SEG=1001100, digit 3 SEG=1001111.
- Blanking: load value=7, blank_lz=1 -> digits 3..1 SEG=1111111, digit 0 SEG=0001111. Load value=0 -> digit 0 shows 0000001.
- Hex mode and overflow: load value=0x2AF, hex_mode=1 -> busy never asserts. One cycle later digits = 0,2,A,F. Load value=12000 decimal -> all four digits show 1111110.
- Ignored load and dp_mask: load 5 then load 9 while busy=1 -> final display 5. dp_mask=0010 -> DP=0 only while AN=1101.
- Reset mid-conversion: rst asserted during cycle 6 of a conversion -> busy=0 immediately, digits all 0. A subsequent load of 42 completes normally.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment display driver.
// Holds the active-low segment patterns (bit 6 = segment a ... bit 0 = segment g),
// the converter state type, the nibble-to-segment decoder and a power-of-ten helper
// used to size the decimal overflow limit at elaboration time.
package seg_pkg;

   localparam logic [6:0] SEG_0     = 7'b0000001;
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_7     = 7'b0001111;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0000100;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b1100000;
   localparam logic [6:0] SEG_C     = 7'b0110001;
   localparam logic [6:0] SEG_D     = 7'b1000010;
   localparam logic [6:0] SEG_E     = 7'b0110000;
   localparam logic [6:0] SEG_F     = 7'b0111000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b1111110;

   typedef enum logic {
      CONV_IDLE,
      CONV_RUN
   } conv_state_e;

   // Decode one hex nibble into its active-low segment pattern.
   function automatic logic [6:0] nibble_to_seg(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
      return seg;
   endfunction

   // 10**n, evaluated at elaboration to form the smallest value that no longer fits.
   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) begin
         p = p * 10;
      end
      return p;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter.
// One bit is shifted in per cycle, MSB first, after every BCD nibble >= 5 gets +3.
// Ports: clk, rst (async, active-high); start (accepted only when idle); bin (value,
// sampled on start); busy (high for exactly VALUE_W cycles); done (one-cycle strobe on
// the final iteration); bcd (final result, valid only while done is high).
// Digits above NUM_DIGITS simply fall off the top of the accumulator.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int VALUE_W    = 14,
   parameter int NUM_DIGITS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [VALUE_W-1:0]      bin,
   output logic                    busy,
   output logic                    done,
   output logic [4*NUM_DIGITS-1:0] bcd
);

   localparam int BW = 4 * NUM_DIGITS;
   localparam int CW = $clog2(VALUE_W + 1);

   conv_state_e        state_q, state_d;
   logic [VALUE_W-1:0] shift_q, shift_d;
   logic [BW-1:0]      acc_q, acc_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [BW-1:0]      adjusted;
   logic [BW-1:0]      stepped;

   // State and datapath registers; reset abandons any conversion in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= CONV_IDLE;
         shift_q <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // One double-dabble step per cycle. The stepped value is exposed on bcd so the
   // final iteration can be written straight into the display register, which keeps
   // the visible digits from ever showing a partial result.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      done     = 1'b0;
      adjusted = acc_q;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (acc_q[4*i +: 4] >= 4'd5) begin
            adjusted[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
         end
      end
      stepped = {adjusted[BW-2:0], shift_q[VALUE_W-1]};
      bcd     = stepped;
      case (state_q)
         CONV_IDLE: begin
            if (start) begin
               state_d = CONV_RUN;
               shift_d = bin;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            acc_d   = stepped;
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(VALUE_W - 1)) begin
               done    = 1'b1;
               state_d = CONV_IDLE;
            end
         end
      endcase
   end

   assign busy = (state_q == CONV_RUN);

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed multi-digit 7-segment driver.
// Ports: clk, rst (async, active-high); value/load/hex_mode/blank_lz (captured on a
// load while idle); dp_mask (live per-digit decimal points); busy (decimal conversion
// running); AN (active-low one-hot-low anodes); SEG (a..g on [6:0], active-low);
// DP (active-low decimal point). AN, SEG and DP are registered together so they
// always switch on the same edge.
module seg_display_mux
   import seg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int VALUE_W     = 14,
   parameter int REFRESH_DIV = 100000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [VALUE_W-1:0]    value,
   input  logic                  load,
   input  logic                  hex_mode,
   input  logic                  blank_lz,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   output logic                  busy,
   output logic [NUM_DIGITS-1:0] AN,
   output logic [6:0]            SEG,
   output logic                  DP
);

   localparam int DW = 4 * NUM_DIGITS;
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam longint unsigned DEC_LIMIT = pow10(NUM_DIGITS);

   logic [PW-1:0]         presc_q, presc_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [DW-1:0]         digits_q, digits_d;
   logic                  overflow_q, overflow_d;
   logic                  blank_q, blank_d;
   logic                  ovfPend_q, ovfPend_d;
   logic                  blankPend_q, blankPend_d;
   logic [NUM_DIGITS-1:0] an_q, an_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;

   logic                  capture;
   logic                  startConv;
   logic                  convBusy;
   logic                  convDone;
   logic [DW-1:0]         convBcd;
   logic [VALUE_W+DW-1:0] valueExt;
   logic                  hexOvf;
   logic                  decOvf;
   logic [3:0]            curNib;
   logic                  curDp;
   logic                  curBlank;
   logic [NUM_DIGITS-1:0] zeroAbove;

   bin2bcd_seq #(
      .VALUE_W   (VALUE_W),
      .NUM_DIGITS(NUM_DIGITS)
   ) u_bin2bcd (
      .clk  (clk),
      .rst  (rst),
      .start(startConv),
      .bin  (value),
      .busy (convBusy),
      .done (convDone),
      .bcd  (convBcd)
   );

   assign busy = convBusy;

   // All state lives here. Outputs reset to dark so nothing lights until the
   // first edge after reset release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q     <= '0;
         idx_q       <= '0;
         digits_q    <= '0;
         overflow_q  <= 1'b0;
         blank_q     <= 1'b0;
         ovfPend_q   <= 1'b0;
         blankPend_q <= 1'b0;
         an_q        <= '1;
         seg_q       <= SEG_BLANK;
         dp_q        <= 1'b1;
      end else begin
         presc_q     <= presc_d;
         idx_q       <= idx_d;
         digits_q    <= digits_d;
         overflow_q  <= overflow_d;
         blank_q     <= blank_d;
         ovfPend_q   <= ovfPend_d;
         blankPend_q <= blankPend_d;
         an_q        <= an_d;
         seg_q       <= seg_d;
         dp_q        <= dp_d;
      end
   end

   // Refresh prescaler: the scan index only moves on the prescaler's terminal count.
   always_comb begin
      presc_d = presc_q + PW'(1);
      idx_d   = idx_q;
      if (presc_q == PW'(REFRESH_DIV - 1)) begin
         presc_d = '0;
         idx_d   = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end
   end

   // Capture and commit. Hex loads go straight into the display register; decimal
   // loads park their overflow/blanking flags until the converter finishes so the
   // flags and digits change on the same edge. Loads during a conversion are dropped.
   always_comb begin
      capture     = load && !convBusy;
      startConv   = capture && !hex_mode;
      valueExt    = {{DW{1'b0}}, value};
      hexOvf      = |(valueExt >> DW);
      decOvf      = (64'(value) >= DEC_LIMIT);
      digits_d    = digits_q;
      overflow_d  = overflow_q;
      blank_d     = blank_q;
      ovfPend_d   = ovfPend_q;
      blankPend_d = blankPend_q;
      if (capture && hex_mode) begin
         digits_d   = valueExt[DW-1:0];
         overflow_d = hexOvf;
         blank_d    = blank_lz;
      end else if (startConv) begin
         ovfPend_d   = decOvf;
         blankPend_d = blank_lz;
      end
      if (convDone) begin
         digits_d   = convBcd;
         overflow_d = ovfPend_q;
         blank_d    = blankPend_q;
      end
   end

   // Select the digit under the scan index and build the next output word.
   // zeroAbove[i] means digit i and every digit above it are zero; digit 0 is
   // never blanked so a zero value still shows a single "0".
   always_comb begin
      curNib    = '0;
      curDp     = 1'b1;
      curBlank  = 1'b0;
      an_d      = '1;
      zeroAbove = '0;
      zeroAbove[NUM_DIGITS-1] = (digits_q[DW-1 -: 4] == 4'd0);
      for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
         zeroAbove[i] = (digits_q[4*i +: 4] == 4'd0) && zeroAbove[i+1];
      end
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IW'(i)) begin
            curNib   = digits_q[4*i +: 4];
            curDp    = ~dp_mask[i];
            curBlank = blank_q && (i != 0) && zeroAbove[i];
            an_d[i]  = 1'b0;
         end
      end
      if (overflow_q) begin
         seg_d = SEG_DASH;
      end else if (curBlank) begin
         seg_d = SEG_BLANK;
      end else begin
         seg_d = nibble_to_seg(curNib);
      end
      dp_d = curDp;
   end

   assign AN  = an_q;
   assign SEG = seg_q;
   assign DP  = dp_q;

endmodule
